// File: rtl/dff_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the
// write arbiter that owns the 8-bit enable register.
package dff_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    localparam int ARB_N_REQ_MAX = 4;
    localparam int ARB_WIDTH     = 8;

    // Returns the first set request bit at or above ptr, wrapping at n_req.
    // Bits at or above n_req are never considered.
    function automatic logic [1:0] rr_winner(
        input logic [ARB_N_REQ_MAX-1:0] req,
        input logic [1:0]               ptr,
        input int                       n_req
    );
        logic [1:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < ARB_N_REQ_MAX; i++) begin
            idx = (int'(ptr) + i) % n_req;
            if (!found && (i < n_req) && req[idx]) begin
                win   = idx[1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/dff_write_arbiter_en_reg.sv
// Plain load-enable register with synchronous active-high reset; this is
// the shared register whose d/en only the arbiter may drive.
module en_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled, otherwise hold the current contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin write arbiter: picks one requester in IDLE, pulses its grant
// for one cycle and loads its data into the shared register on that cycle.
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N_REQ = ARB_N_REQ_MAX,
    parameter int WIDTH = ARB_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic [1:0]             owner,
    output logic                   busy
);

    arb_state_t               state;
    arb_state_t               state_next;
    logic [N_REQ-1:0]         gnt_next;
    logic [1:0]               sel;
    logic [1:0]               sel_next;
    logic [1:0]               ptr;
    logic [1:0]               ptr_next;
    logic [1:0]               owner_next;
    logic [ARB_N_REQ_MAX-1:0] req_pad;
    logic [1:0]               winner;
    logic                     reg_en;
    logic [WIDTH-1:0]         reg_d;

    // Widen req to the package maximum so the shared pick function can be used.
    always_comb begin
        req_pad             = '0;
        req_pad[N_REQ-1:0]  = req;
    end

    assign winner = rr_winner(req_pad, ptr, N_REQ);

    // Register write happens during GRANT using the latched selection, so
    // req changes in that cycle cannot affect which data is written.
    assign reg_en = (state == ARB_GRANT);
    assign reg_d  = wdata[sel*WIDTH +: WIDTH];
    assign busy   = (state == ARB_GRANT);

    // Next-state and next-value logic for the IDLE/GRANT sequencer.
    always_comb begin
        state_next = state;
        gnt_next   = gnt;
        sel_next   = sel;
        ptr_next   = ptr;
        owner_next = owner;
        case (state)
            ARB_IDLE: begin
                if (|req) begin
                    state_next = ARB_GRANT;
                    gnt_next   = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
                    sel_next   = winner;
                end
            end
            ARB_GRANT: begin
                state_next = ARB_IDLE;
                gnt_next   = '0;
                owner_next = sel;
                ptr_next   = (sel == 2'(N_REQ-1)) ? 2'd0 : sel + 2'd1;
            end
            default: begin
                state_next = ARB_IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    // State, grant, selection, pointer and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
            gnt   <= '0;
            sel   <= '0;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_next;
            gnt   <= gnt_next;
            sel   <= sel_next;
            ptr   <= ptr_next;
            owner <= owner_next;
        end
    end

    en_reg #(
        .WIDTH(WIDTH)
    ) u_en_reg (
        .clk(clk),
        .rst(rst),
        .en (reg_en),
        .d  (reg_d),
        .q  (q)
    );

endmodule
